// File: rtl/periph_mem_responder.sv
// Register window + GNSS sample FIFO on the MCU peripheral memory bus.
// Two-state bus handshake: commit in IDLE, one-cycle ready pulse in RESP.
module periph_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        irq
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          LW    = AW + 1;
  localparam logic [31:0] ID    = 32'h474E_5301;

  typedef enum logic {IDLE, RESP} state_t;
  state_t state;

  logic [1:0]    ctrl;
  logic [31:0]   scratch;
  logic [7:0]    thresh;
  logic          overflow;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic [7:0]    level8;

  logic       commit, hit, wr, empty, full;
  logic       pop, push, push_req, clr, ovf_set, ovf_clr;
  logic [5:0] off;
  logic [31:0] rd_val;
  logic       unused_addr;

  assign unused_addr = &{1'b0, mem_addr[1:0]};

  assign commit   = (state == IDLE) && mem_valid;
  assign hit      = commit && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign off      = mem_addr[7:2];
  assign wr       = |mem_wstrb;
  assign level8   = 8'(level);
  assign empty    = (level == '0);
  assign full     = (level == LW'(FIFO_DEPTH));

  assign pop      = hit && !wr && (off == 6'h03) && !empty;
  assign clr      = hit && wr && (off == 6'h01) && mem_wstrb[0] && mem_wdata[2];
  assign push_req = sample_valid && ctrl[0];
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign push     = push_req && (!full || pop) && !clr;
  assign ovf_set  = push_req && full && !pop && !clr;
  assign ovf_clr  = hit && wr && (off == 6'h02) && mem_wstrb[1] && mem_wdata[10];

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (off)
        6'h00: rd_val = ID;
        6'h01: rd_val = {30'd0, ctrl};
        6'h02: rd_val = {21'd0, overflow, full, empty, level8};
        6'h03: rd_val = empty ? 32'd0 : fifo_mem[rd_ptr];
        6'h04: rd_val = scratch;
        6'h05: rd_val = {24'd0, thresh};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ctrl      <= '0;
      scratch   <= '0;
      thresh    <= '0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      irq       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_valid) begin
          state     <= RESP;
          mem_ready <= 1'b1;
          if (!wr) mem_rdata <= rd_val;
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (hit && wr) begin
        case (off)
          6'h01: if (mem_wstrb[0]) ctrl <= mem_wdata[1:0];
          6'h04: for (int b = 0; b < 4; b++)
                   if (mem_wstrb[b]) scratch[8*b +: 8] <= mem_wdata[8*b +: 8];
          6'h05: if (mem_wstrb[0]) thresh <= mem_wdata[7:0];
          default: ;
        endcase
      end

      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end

      overflow <= ovf_set | (overflow & ~ovf_clr);
      irq      <= ctrl[1] && (((thresh != 8'd0) && (level8 >= thresh)) || overflow);
    end
  end
endmodule

// File: tb/tb_periph_mem_responder.sv
// Randomized scoreboard bench for periph_mem_responder against a queue-based model.
module tb_periph_mem_responder;
  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam int          DEPTH = 16;
  localparam logic [31:0] ID    = 32'h474E_5301;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic        irq;

  always #5 sys_clk = ~sys_clk;

  periph_mem_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .sample_valid(sample_valid), .sample_data(sample_data), .irq(irq)
  );

  typedef struct { bit rd; logic [31:0] data; } sb_t;
  sb_t sb[$];

  int n_chk = 0, n_pass = 0;

  // Reference model state
  int unsigned fq[$];
  logic [1:0]  m_ctrl;
  logic [31:0] m_scr;
  logic [7:0]  m_thr;
  bit          m_ovf, exp_irq;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    fq.delete();
    m_ctrl = '0; m_scr = '0; m_thr = '0; m_ovf = 0; exp_irq = 0;
  endtask

  // Applies one clock edge to the model; inputs are those sampled at that edge.
  task automatic model_edge(bit v, logic [31:0] a, logic [31:0] wd, logic [3:0] ws,
                            bit p, logic [31:0] sd);
    int sz = fq.size();
    bit in_win = (a[31:8] == BASE[31:8]);
    int off = int'(a[7:2]);
    bit is_wr = (ws != 4'd0);
    bit full = (sz == DEPTH);
    bit pop = 0, clr = 0;
    logic [31:0] rv = '0;
    exp_irq = m_ctrl[1] && (((m_thr != 0) && (sz >= int'(m_thr))) || m_ovf);
    if (v && in_win) begin
      if (!is_wr) begin
        case (off)
          0: rv = ID;
          1: rv = {30'd0, m_ctrl};
          2: rv = {21'd0, m_ovf, full, sz == 0, 8'(sz)};
          3: if (sz > 0) begin rv = fq[0]; pop = 1; end
          4: rv = m_scr;
          5: rv = {24'd0, m_thr};
          default: rv = '0;
        endcase
      end else begin
        clr = (off == 1) && ws[0] && wd[2];
        if (off == 2 && ws[1] && wd[10]) m_ovf = 0;
      end
    end
    if (v) sb.push_back('{!is_wr, rv});
    if (clr) fq.delete();
    else begin
      if (pop) void'(fq.pop_front());
      if (p && m_ctrl[0]) begin
        if (!full || pop) fq.push_back(sd);
        else m_ovf = 1;
      end
    end
    if (v && in_win && is_wr) begin
      if (off == 1 && ws[0]) m_ctrl = wd[1:0];
      if (off == 4) for (int b = 0; b < 4; b++) if (ws[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
      if (off == 5 && ws[0]) m_thr = wd[7:0];
    end
  endtask

  task automatic cyc(bit v, logic [31:0] a, logic [31:0] wd, logic [3:0] ws,
                     bit p, logic [31:0] sd);
    mem_valid = v; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    sample_valid = p; sample_data = sd;
    @(posedge sys_clk);
    model_edge(v, a, wd, ws, p, sd);
    #1;
    chk("irq", {31'd0, irq}, {31'd0, exp_irq});
  endtask

  task automatic acc(logic [31:0] a, logic [31:0] wd, logic [3:0] ws,
                     bit p0, logic [31:0] d0, bit p1, logic [31:0] d1);
    cyc(1, a, wd, ws, p0, d0);
    chk("ready_rise", {31'd0, mem_ready}, 32'd1);
    cyc(0, '0, '0, '0, p1, d1);
    chk("ready_fall", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic rd(logic [31:0] a);
    acc(a, '0, 4'd0, 0, '0, 0, '0);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] wd, logic [3:0] ws);
    acc(a, wd, ws, 0, '0, 0, '0);
  endtask

  task automatic push_idle(logic [31:0] d);
    cyc(0, '0, '0, '0, 1, d);
  endtask

  // Monitor: every ready pulse consumes one scoreboard entry.
  always @(negedge sys_clk) begin : mon
    sb_t e;
    if (mem_ready === 1'b1) begin
      if (sb.size() == 0) chk("ready_spurious", {31'd0, mem_ready}, 32'd0);
      else begin
        e = sb.pop_front();
        if (e.rd) chk("rdata", mem_rdata, e.data);
      end
    end
  end

  logic [31:0] ra, rwd;
  logic [3:0]  rws;

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    model_reset();
    rst_n = 1'b1;

    rd(BASE);
    chk("id", mem_rdata, ID);
    rd(32'h0300_0000);
    chk("out_of_window", mem_rdata, 32'd0);
    rd(BASE + 32'h08);
    chk("status_reset", mem_rdata, 32'h0000_0100);

    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'h10, 32'h1234_5678, 4'b0101);
    rd(BASE + 32'h10);
    chk("scratch_merge", mem_rdata, 32'hFF34_FF78);

    wr(BASE + 32'h04, 32'h1, 4'h1);
    push_idle(32'hAAAA_0001);
    push_idle(32'hBBBB_0002);
    push_idle(32'hCCCC_0003);
    rd(BASE + 32'h08);
    chk("level3", {24'd0, mem_rdata[7:0]}, 32'd3);
    rd(BASE + 32'h0C); chk("pop_a", mem_rdata, 32'hAAAA_0001);
    rd(BASE + 32'h0C); chk("pop_b", mem_rdata, 32'hBBBB_0002);
    rd(BASE + 32'h0C); chk("pop_c", mem_rdata, 32'hCCCC_0003);
    rd(BASE + 32'h0C); chk("pop_empty", mem_rdata, 32'd0);
    rd(BASE + 32'h08); chk("empty_flag", {31'd0, mem_rdata[8]}, 32'd1);

    for (int i = 0; i < 17; i++) push_idle(32'h100 + 32'(i));
    rd(BASE + 32'h08);
    chk("full_ovf", {21'd0, mem_rdata[10:0]}, 32'h0000_0610);
    wr(BASE + 32'h08, 32'h0000_0400, 4'b0010);
    rd(BASE + 32'h08);
    chk("ovf_clear", {21'd0, mem_rdata[10:0]}, 32'h0000_0210);

    wr(BASE + 32'h04, 32'h4, 4'h1);
    wr(BASE + 32'h14, 32'h4, 4'h1);
    wr(BASE + 32'h04, 32'h3, 4'h1);
    for (int i = 0; i < 4; i++) push_idle(32'h200 + 32'(i));
    chk("irq_lag", {31'd0, irq}, 32'd0);
    cyc(0, '0, '0, '0, 0, '0);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h0C);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    rd(BASE + 32'h3C);
    chk("unmapped", mem_rdata, 32'd0);

    wr(BASE + 32'h04, 32'h5, 4'h1);
    for (int i = 0; i < 5; i++) push_idle(32'h300 + 32'(i));
    acc(BASE + 32'h0C, '0, 4'd0, 1, 32'h0000_0399, 0, '0);
    rd(BASE + 32'h08);
    chk("push_pop_level", {24'd0, mem_rdata[7:0]}, 32'd5);
    acc(BASE + 32'h04, 32'h5, 4'h1, 1, 32'h0000_0400, 0, '0);
    rd(BASE + 32'h08);
    chk("clear_with_push", mem_rdata, 32'h0000_0100);

    // Reset while a read response is in flight
    for (int i = 0; i < 3; i++) push_idle(32'h500 + 32'(i));
    cyc(1, BASE + 32'h0C, '0, 4'd0, 0, '0);
    chk("ready_pre_rst", {31'd0, mem_ready}, 32'd1);
    rst_n = 1'b0; mem_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    rd(BASE + 32'h08);
    chk("rst_fifo", mem_rdata, 32'h0000_0100);

    wr(BASE + 32'h04, 32'h3, 4'h1);
    wr(BASE + 32'h14, 32'h6, 4'h1);
    for (int it = 0; it < 400; it++) begin
      ra = BASE + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = 32'h0400_0000 | 32'($urandom_range(0, 255));
      rws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rwd = $urandom;
      if (ra[7:2] == 6'h01 && $urandom_range(0, 7) != 0) rwd[2] = 1'b0;
      if (ra[7:2] == 6'h05) rwd = 32'($urandom_range(0, 20));
      acc(ra, rwd, rws, $urandom_range(0, 2) != 0, $urandom,
          $urandom_range(0, 2) != 0, $urandom);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        cyc(0, '0, '0, '0, $urandom_range(0, 1) == 1, $urandom);
    end

    repeat (3) cyc(0, '0, '0, '0, 0, '0);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
